// File: rtl/bypass_symbol_collector_pkg.sv
// Shared types, sizing constants and helpers for the bypass symbol collector.
package bypass_symbol_collector_pkg;

  localparam int MAX_BINS_PER_CYCLE = 4;
  localparam int BIN_WIDTH          = MAX_BINS_PER_CYCLE;
  localparam int MAX_LEN            = 16;
  localparam int LEN_W              = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Bins to request this cycle minus one: min(remaining, MAX_BINS_PER_CYCLE) - 1.
  // A zero remaining count maps to 0 so the select never wraps.
  function automatic logic [1:0] calc_n_bin(input logic [LEN_W-1:0] remaining);
    logic [1:0] n;
    if (remaining >= LEN_W'(MAX_BINS_PER_CYCLE)) begin
      n = 2'(MAX_BINS_PER_CYCLE - 1);
    end else if (remaining == '0) begin
      n = 2'd0;
    end else begin
      n = 2'(remaining - LEN_W'(1));
    end
    return n;
  endfunction

  // Out-of-range requested lengths are clamped to the longest legal symbol.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/bypass_symbol_collector_if.sv
// Request, decoder-bin and symbol-handoff signals of the bypass symbol collector.
interface bypass_symbol_collector_if;
  import bypass_symbol_collector_pkg::*;

  logic                 start;
  logic [LEN_W-1:0]     sym_len;
  logic                 busy;
  logic                 bin_req;
  logic [1:0]           n_bin;
  logic                 bin_valid;
  logic [BIN_WIDTH-1:0] bin_in;
  logic                 sym_valid;
  logic                 sym_ready;
  logic [MAX_LEN-1:0]   sym_data;
  logic [LEN_W-1:0]     sym_len_out;

  // Environment side: issues requests, supplies bins, consumes symbols.
  modport master (
    output start, sym_len, bin_valid, bin_in, sym_ready,
    input  busy, bin_req, n_bin, sym_valid, sym_data, sym_len_out
  );

  // Collector side.
  modport slave (
    input  start, sym_len, bin_valid, bin_in, sym_ready,
    output busy, bin_req, n_bin, sym_valid, sym_data, sym_len_out
  );

endinterface

// File: rtl/bypass_symbol_collector_bin_order_merge.sv
// Appends k freshly decoded bins to the accumulator. The decoder delivers the
// first bin in bit 0, but the symbol is built MSB-first, so the k bins are
// reversed before being shifted in below the existing accumulator bits.
module bin_order_merge
  import bypass_symbol_collector_pkg::*;
(
  input  logic [MAX_LEN-1:0]   acc,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic [2:0]           k,
  output logic [MAX_LEN-1:0]   acc_next
);

  logic [BIN_WIDTH-1:0] bins_rev;

  // Reverse bin order so bin_in[0] lands in the most significant position.
  always_comb begin
    bins_rev = '0;
    for (int i = 0; i < BIN_WIDTH; i++) begin
      bins_rev[i] = bin_in[BIN_WIDTH-1-i];
    end
  end

  // Shift the accumulator by k and fill with the top k reversed bins.
  always_comb begin
    acc_next = acc;
    unique case (k)
      3'd1:    acc_next = {acc[MAX_LEN-2:0], bins_rev[3]};
      3'd2:    acc_next = {acc[MAX_LEN-3:0], bins_rev[3:2]};
      3'd3:    acc_next = {acc[MAX_LEN-4:0], bins_rev[3:1]};
      3'd4:    acc_next = {acc[MAX_LEN-5:0], bins_rev[3:0]};
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/bypass_symbol_collector.sv
// Collects 1..4 bypass bins per cycle from the EP decoder into a fixed-length
// symbol and hands it to the syntax stage on a valid/ready handshake.
module bypass_symbol_collector
  import bypass_symbol_collector_pkg::*;
(
  input logic                      clk,
  input logic                      rst_n,
  bypass_symbol_collector_if.slave bus
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [MAX_LEN-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [1:0]         n_bin;
  logic [2:0]         k;
  logic [MAX_LEN-1:0] acc_merged;
  logic [LEN_W-1:0]   start_len;
  logic               handoff;

  bin_order_merge u_merge (
    .acc      (acc_q),
    .bin_in   (bus.bin_in),
    .k        (k),
    .acc_next (acc_merged)
  );

  assign start_len = clamp_len(bus.sym_len);
  assign n_bin     = (state_q == COLLECT) ? calc_n_bin(remaining_q) : 2'd0;
  assign k         = {1'b0, n_bin} + 3'd1;
  assign handoff   = (state_q == HOLD) && bus.sym_ready;

  assign bus.busy        = (state_q != IDLE);
  assign bus.bin_req     = (state_q == COLLECT);
  assign bus.n_bin       = n_bin;
  assign bus.sym_valid   = (state_q == HOLD);
  assign bus.sym_data    = acc_q;
  assign bus.sym_len_out = len_q;

  // Next-state logic: accept requests, absorb bins, and release symbols.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    len_d       = len_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d       = start_len;
          remaining_d = start_len;
          acc_d       = '0;
          state_d     = (start_len == '0) ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.bin_valid) begin
          acc_d       = acc_merged;
          remaining_d = remaining_q - LEN_W'(k);
          if (remaining_d == '0) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (handoff) begin
          if (bus.start) begin
            len_d       = start_len;
            remaining_d = start_len;
            acc_d       = '0;
            state_d     = (start_len == '0) ? HOLD : COLLECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
    end
  end

endmodule

// File: tb/tb_bypass_symbol_collector.sv
// Randomized scoreboard bench for the bypass symbol collector. Requests are
// symbols (length, value); the reference model turns each into its bin
// sequence MSB-first and predicts per-cycle handshake outputs from queue sizes.
module tb_bypass_symbol_collector;
  import bypass_symbol_collector_pkg::*;

  typedef struct {
    logic [LEN_W-1:0]   raw_len;
    logic [MAX_LEN-1:0] value;
  } req_t;

  typedef struct {
    logic [MAX_LEN-1:0] data;
    logic [LEN_W-1:0]   len;
  } sym_t;

  logic clk = 1'b0;
  logic rst_n;

  bypass_symbol_collector_if bus();

  bypass_symbol_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit   bit_q[$];
  sym_t exp_q[$];
  req_t req_q[$];
  bit   pending = 1'b0;

  bit   acc_start = 1'b0;
  req_t acc_req;
  int   acc_k = 0;
  bit   acc_handoff = 1'b0;

  int valid_mode = 1;
  int p_valid = 100;
  int p_ready = 100;
  int p_noise = 0;
  bit junk = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  function automatic int eff_len(input logic [LEN_W-1:0] raw);
    return (int'(raw) > MAX_LEN) ? MAX_LEN : int'(raw);
  endfunction

  task automatic pushReq(input int raw, input logic [MAX_LEN-1:0] value);
    req_t r;
    r.raw_len = LEN_W'(raw);
    r.value   = value;
    req_q.push_back(r);
  endtask

  task automatic pushRandomReq();
    int raw;
    int n;
    logic [MAX_LEN-1:0] mask;
    raw  = int'($urandom_range(0, 20));
    n    = eff_len(LEN_W'(raw));
    mask = '0;
    for (int i = 0; i < n; i++) mask[i] = 1'b1;
    pushReq(raw, MAX_LEN'($urandom) & mask);
  endtask

  // One clock of environment: account for the last edge, check, then drive.
  task automatic applyStimulus();
    int  k;
    bit  collecting;
    bit  acceptable;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_handoff) pending = 1'b0;
    for (int i = 0; i < acc_k; i++) void'(bit_q.pop_front());
    if (acc_k > 0 && bit_q.size() == 0) pending = 1'b1;
    if (acc_start) begin
      int   n;
      sym_t s;
      n      = eff_len(acc_req.raw_len);
      s.data = acc_req.value;
      s.len  = LEN_W'(n);
      exp_q.push_back(s);
      for (int i = 0; i < n; i++) bit_q.push_back(acc_req.value[n-1-i]);
      if (n == 0) pending = 1'b1;
    end

    collecting = (bit_q.size() != 0);
    k = collecting ? ((bit_q.size() >= MAX_BINS_PER_CYCLE) ? MAX_BINS_PER_CYCLE : bit_q.size()) : 0;
    checkOutput("busy", 32'(bus.busy), 32'(collecting || pending));
    checkOutput("bin_req", 32'(bus.bin_req), 32'(collecting));
    checkOutput("n_bin", 32'(bus.n_bin), collecting ? k - 1 : 0);
    checkOutput("sym_valid", 32'(bus.sym_valid), 32'(pending));

    bus.sym_ready = (int'($urandom_range(0, 99)) < p_ready);
    case (valid_mode)
      1:       bus.bin_valid = 1'b1;
      2:       bus.bin_valid = (cyc % 3 == 0);
      default: bus.bin_valid = (int'($urandom_range(0, 99)) < p_valid);
    endcase
    for (int j = 0; j < BIN_WIDTH; j++) begin
      bus.bin_in[j] = (j < k) ? bit_q[j] : (junk ? 1'($urandom) : 1'b0);
    end

    acceptable  = (!collecting && !pending) || (pending && bus.sym_ready);
    acc_handoff = pending && bus.sym_ready;
    acc_k       = (collecting && bus.bin_valid) ? k : 0;
    acc_start   = 1'b0;
    bus.start   = 1'b0;
    bus.sym_len = LEN_W'($urandom_range(0, MAX_LEN));
    if (acceptable && req_q.size() > 0) begin
      r           = req_q.pop_front();
      bus.start   = 1'b1;
      bus.sym_len = r.raw_len;
      acc_start   = 1'b1;
      acc_req     = r;
    end else if (!acceptable && int'($urandom_range(0, 99)) < p_noise) begin
      bus.start = 1'b1;
    end
  endtask

  task automatic applyReset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.bin_valid = 1'b0;
    bus.sym_ready = 1'b0;
    bus.bin_in    = '0;
    bus.sym_len   = '0;
    @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_bin_req", 32'(bus.bin_req), 0);
    checkOutput("rst_n_bin", 32'(bus.n_bin), 0);
    checkOutput("rst_sym_valid", 32'(bus.sym_valid), 0);
    checkOutput("rst_sym_data", 32'(bus.sym_data), 0);
    checkOutput("rst_sym_len_out", 32'(bus.sym_len_out), 0);
    rst_n = 1'b1;
    bit_q.delete();
    exp_q.delete();
    pending     = 1'b0;
    acc_start   = 1'b0;
    acc_k       = 0;
    acc_handoff = 1'b0;
  endtask

  function automatic bit modelIdle();
    return (req_q.size() == 0) && !acc_start && (bit_q.size() == 0) && !pending;
  endfunction

  task automatic runUntilIdle(input int max_cycles);
    int n = 0;
    while (!modelIdle() && n < max_cycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("idle_timeout", 32'(modelIdle()), 1);
  endtask

  // Monitor: every presented symbol must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.sym_valid === 1'b1) begin
        checkOutput("sb_has_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          checkOutput("sym_data", 32'(bus.sym_data), 32'(exp_q[0].data));
          checkOutput("sym_len_out", 32'(bus.sym_len_out), 32'(exp_q[0].len));
          if (bus.sym_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    applyReset();

    $display("[TB] len=6 two-cycle symbol");
    pushReq(6, 16'h0035);
    runUntilIdle(30);

    $display("[TB] len=16 full-width symbol");
    pushReq(16, 16'hF081);
    runUntilIdle(30);

    $display("[TB] len=3 then len=0 back-to-back");
    pushReq(3, 16'h0005);
    pushReq(0, 16'h0000);
    runUntilIdle(30);

    $display("[TB] backpressure with ignored start");
    p_ready = 0;
    pushReq(4, 16'h000A);
    guard = 0;
    while (!pending && guard < 30) begin
      applyStimulus();
      guard++;
    end
    checkOutput("bp_reached_hold", 32'(pending), 1);
    p_noise = 100;
    repeat (5) applyStimulus();
    p_noise = 0;
    p_ready = 100;
    runUntilIdle(30);

    $display("[TB] oversize length clamps");
    pushReq(20, 16'hBEEF);
    runUntilIdle(30);

    $display("[TB] stalls then reset mid-collect");
    valid_mode = 2;
    pushReq(9, 16'h01A5);
    guard = 0;
    while (bit_q.size() != 5 && guard < 40) begin
      applyStimulus();
      guard++;
    end
    checkOutput("stall_consumed_four", bit_q.size(), 5);
    applyReset();
    valid_mode = 1;
    pushReq(1, 16'h0001);
    runUntilIdle(30);

    $display("[TB] randomized traffic");
    valid_mode = 0;
    p_valid    = 60;
    p_ready    = 70;
    p_noise    = 10;
    junk       = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (req_q.size() == 0 && $urandom_range(0, 3) == 0) pushRandomReq();
      applyStimulus();
    end

    p_noise    = 0;
    p_ready    = 100;
    valid_mode = 1;
    runUntilIdle(200);
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bypass_symbol_collector.md
Name: bypass_symbol_collector

Overview:
- Sits directly downstream of the multi-bin bypass (EP) decoder.
- Drives the decoder's per-cycle bin-count select and accepts its 1-4 bypass bins per cycle.
- Assembles the bins MSB-first into a fixed-length symbol of 1..MAX_LEN bits, e.g. coefficient remainder suffixes and fixed-length syntax elements.
- Presents each completed symbol on a valid/ready handshake to the binarization/syntax stage.

Parameters:
- BIN_WIDTH, 4: maximum bins accepted per cycle; must match the decoder's bin output width.
- MAX_LEN, 16: maximum symbol length in bins.
- LEN_W, 5: width of length and counter fields; must be at least clog2(MAX_LEN+1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new symbol; sampled only in IDLE, or in HOLD together with handoff.
- sym_len  input  LEN_W  symbol length in bins, sampled with an accepted start; legal range 0..MAX_LEN.
- busy  output  1  high in COLLECT or HOLD.
- bin_req  output  1  high in COLLECT; the decoder must advance its value only when bin_req && bin_valid.
- n_bin  output  2  bins requested this cycle minus one, = min(remaining,BIN_WIDTH)-1; 0 outside COLLECT.
- bin_valid  input  1  decoder bins valid this cycle.
- bin_in  input  BIN_WIDTH  decoder bins; bit 0 is the first-decoded bin.
- sym_valid  output  1  symbol available.
- sym_ready  input  1  consumer accepts the symbol.
- sym_data  output  MAX_LEN  symbol, right-aligned, first bin in the MSB position of the symbol length.
- sym_len_out  output  LEN_W  length of the presented symbol.

Behaviour:
- Reset: the clk edge with rst_n low forces state IDLE. All outputs go to 0, including busy, bin_req, n_bin, sym_valid, sym_data and sym_len_out. The accumulator and remaining counter are cleared. Reset mid-COLLECT or mid-HOLD discards the partial or pending symbol, with no handoff.
- IDLE, start=1, sym_len>0: latch the length; remaining=sym_len, acc=0; go to COLLECT next cycle.
- IDLE, start=1, sym_len=0: go to HOLD with sym_data=0 and sym_len_out=0, without visiting COLLECT.
- IDLE, start=1, sym_len>MAX_LEN: illegal; the length is clamped to MAX_LEN.
- COLLECT: bin_req=1 and n_bin=min(remaining,4)-1, combinational from registered state.
  - On bin_valid with k=n_bin+1, append bins in order bin_in[0]..bin_in[k-1]: acc=(acc<<k)|{bin_in[0],bin_in[1],...,bin_in[k-1]}, so bin_in[0] becomes the most significant of the new k bits.
  - remaining -= k. Bits of bin_in at or above k are ignored.
  - If remaining becomes 0, go to HOLD next cycle; sym_valid rises the cycle after the final bin_valid.
  - Without bin_valid, hold state. There is no timeout.
- HOLD: sym_valid=1; sym_data and sym_len_out are stable until handoff.
  - Handoff occurs when sym_ready=1.
  - Handoff with start=1 in the same cycle: accept the new request and go directly to COLLECT (or back to HOLD if sym_len=0). This gives back-to-back symbols with no IDLE bubble.
  - Handoff without start: go to IDLE; sym_valid drops next cycle; sym_data keeps its last value.
- start outside IDLE and outside HOLD-with-handoff is ignored, with no queueing.
- Throughput: ceil(len/4) collect cycles plus 1 HOLD cycle per symbol under continuous bin_valid and sym_ready.
- Width rules:
  - acc is MAX_LEN bits; shift overflow cannot occur because k never exceeds remaining.
  - remaining never underflows.
  - sym_data bits at or above sym_len_out are 0.

Decomposition:
- Shared package holds:
  - state enum IDLE/COLLECT/HOLD.
  - constants MAX_BINS_PER_CYCLE=4, MAX_LEN=16, LEN_W.
  - function computing n_bin from remaining.
- One sub-module: bin_order_merge. It is combinational: it takes acc, bin_in and k, and returns the updated accumulator, including the bit reversal and shift.
- FSM, counter and handshake stay in the top level.

Test Plan:
- len=6: bin_valid with bin_in=4'b1011 (n_bin=3), then bin_in=4'b0010 (n_bin=1). Required: sym_data=16'h0035 and sym_len_out=6, with sym_valid exactly one cycle after the second bin_valid.
- len=16, bin_in=4'hF then 4'h0, 4'h1, 4'h8 under continuous bin_valid. Required: n_bin=3 on all four cycles and sym_data=16'hF081.
- len=3 then len=0 back-to-back, with start held during handoff. Required: bins 1,0,1 via bin_in=4'b0101 and n_bin=2 give sym_data=16'h0005. The next cycle is HOLD with sym_data=0 and sym_len_out=0, with no IDLE cycle.
- Backpressure: len=4 completes while sym_ready=0 for 5 cycles. Required: sym_valid and sym_data stay stable; bin_req=0; a start pulse during this time is ignored.
- Stall and reset: len=9, bin_valid gaps of 2 cycles; then rst_n=0 mid-COLLECT after 4 bins. Required: bin_req and n_bin hold across the gaps. The reset clock edge returns IDLE with all outputs 0. A following len=1 with bin_in[0]=1 yields sym_data=1.
